uart_rx_capture: RTL and testbench
==================================

UART_RX_CAPTURE -- requirements
Module: uart_rx_capture

Interface
REQ-001 Parameter CLK_DIV, default 104, clk cycles per UART bit; legal range 4..65535.
REQ-002 Parameter FIFO_DEPTH, default 16, receive FIFO entries; power of two, 2..256.
REQ-003 Port clk  input  1  single clock; all logic on its rising edge.
REQ-004 Port rst  input  1  reset, synchronous, active-high.
REQ-005 Port rx  input  1  serial line from the DUT ser_tx, idle high, asynchronous to clk.
REQ-006 Port out_data  output  8  byte at FIFO head.
REQ-007 Port out_valid  output  1  FIFO non-empty.
REQ-008 Port out_ready  input  1  consumer accepts head byte when out_valid & out_ready.
REQ-009 Port fifo_level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
REQ-010 Port frame_err  output  1  sticky, stop bit sampled low.
REQ-011 Port overflow  output  1  sticky, byte dropped because FIFO full.
REQ-012 Port clr_flags  input  1  one-cycle pulse clearing frame_err and overflow.

Function
REQ-013 rx SHALL pass through a 2-flop synchronizer; rx_s denotes its output; all decisions use rx_s only.
REQ-014 Receiver FSM SHALL have states IDLE, START, DATA, STOP, BREAK; 8N1 format, LSB first.
REQ-015 IDLE: rx_s==0 -> START, bit counter loaded so the start sample falls CLK_DIV/2 (integer division) cycles later.
REQ-016 START sample: rx_s==1 -> IDLE (glitch, no flag, no push); rx_s==0 -> DATA, bit index 0.
REQ-017 DATA: each bit sampled exactly CLK_DIV cycles after the previous sample; after bit 7 -> STOP.
REQ-018 STOP: sampled CLK_DIV cycles after bit 7; rx_s==1 -> push byte, -> IDLE same cycle; rx_s==0 -> discard byte, set frame_err, -> BREAK.
REQ-019 BREAK: remain until rx_s==1, then -> IDLE; no new start detected while in BREAK.
REQ-020 FIFO SHALL be first-word-fall-through: out_data/out_valid reflect head combinationally from registers; pushed byte visible with out_valid high the cycle after the stop-sample cycle.
REQ-021 Pop occurs on out_valid & out_ready; out_ready with FIFO empty is ignored.
REQ-022 Push when full without pop: byte dropped, overflow set, FIFO contents unchanged.
REQ-023 Push and pop same cycle when full: push accepted, level unchanged, overflow not set.
REQ-024 Push and pop same cycle when empty: no bypass; byte stored, level becomes 1.
REQ-025 Read/write pointers SHALL wrap modulo FIFO_DEPTH; fifo_level ranges 0..FIFO_DEPTH exactly.
REQ-026 clr_flags SHALL clear both sticky flags next cycle; a set event in the same cycle wins (flag stays 1).
REQ-027 Byte reception SHALL continue independently of consumer stalls; no back-pressure on rx.

Reset
REQ-028 On rst: FSM IDLE, counters 0, synchronizer flops 1, FIFO pointers 0, out_valid 0, out_data 0, fifo_level 0, frame_err 0, overflow 0.
REQ-029 rst asserted mid-frame SHALL abort the frame without push or flag; after release a low rx_s starts a fresh frame.
REQ-030 Outputs SHALL take reset values on the first clk edge with rst high.

Verification (CLK_DIV=8, FIFO_DEPTH=4)
REQ-031 Send 0xA5 with valid stop, out_ready=0 -> out_valid=1, out_data=0xA5, fifo_level=1, flags 0; 1 cycle of out_ready -> level 0.
REQ-032 rx low for 3 cycles then high -> no push, no flag, FSM back in IDLE; following 0x3C received correctly.
REQ-033 Send 0x55 with stop bit low, hold rx low 40 cycles -> frame_err=1, level 0, no spurious start; then 0x01 -> received; clr_flags -> frame_err=0.
REQ-034 Send 0x10..0x14 with out_ready=0 -> level 4, overflow=1, pops yield 0x10,0x11,0x12,0x13 in order.
REQ-035 FIFO full, out_ready=1 held across arrival of 0x77 -> push accepted at stop-sample cycle, overflow=0, 0x77 read last.
REQ-036 rst pulse during bit 4 of 0xFF -> level 0, flags 0; next byte 0x81 received exactly.

Source files
------------

// File: rtl/uart_rx_capture.sv
// uart_rx_capture: 8N1 UART receiver with a first-word-fall-through byte FIFO.
// The serial input is synchronised, framed by a five-state receiver FSM and
// completed bytes are queued for a ready/valid consumer. Framing errors and
// FIFO overflows are reported through sticky flags that clr_flags clears.
module uart_rx_capture #(
    parameter int CLK_DIV    = 104,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rx,
    output logic [7:0]                    out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          frame_err,
    output logic                          overflow,
    input  logic                          clr_flags
);

    localparam int              AW         = $clog2(FIFO_DEPTH);
    localparam logic [15:0]     HALF_LOAD  = 16'(CLK_DIV / 2 - 1);
    localparam logic [15:0]     BIT_LOAD   = 16'(CLK_DIV - 1);
    localparam logic [AW:0]     FULL_LEVEL = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    logic          r_rx_meta;
    logic          r_rx_s;
    state_t        r_state;
    state_t        w_state_next;
    logic [15:0]   r_cnt;
    logic [15:0]   w_cnt_next;
    logic [2:0]    r_bit_idx;
    logic [2:0]    w_bit_idx_next;
    logic [7:0]    r_shift;
    logic [7:0]    w_shift_next;
    logic          w_tick;
    logic          w_push_req;
    logic          w_frame_set;

    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_level;
    logic          w_full;
    logic          w_pop;
    logic          w_push;
    logic          w_ovf_set;

    // Two-flop synchroniser; both flops reset to the idle line level.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    // The sample point of the current bit is reached when the down-counter hits zero.
    assign w_tick = (r_cnt == 16'd0);

    // Receiver next-state logic: bit timing, shift register and push/flag strobes.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = r_cnt;
        w_bit_idx_next = r_bit_idx;
        w_shift_next   = r_shift;
        w_push_req     = 1'b0;
        w_frame_set    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!r_rx_s) begin
                    w_state_next = S_START;
                    w_cnt_next   = HALF_LOAD;
                end
            end
            S_START: begin
                if (!w_tick) begin
                    w_cnt_next = r_cnt - 16'd1;
                end else if (r_rx_s) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_state_next   = S_DATA;
                    w_cnt_next     = BIT_LOAD;
                    w_bit_idx_next = 3'd0;
                end
            end
            S_DATA: begin
                if (!w_tick) begin
                    w_cnt_next = r_cnt - 16'd1;
                end else begin
                    w_shift_next = {r_rx_s, r_shift[7:1]};
                    w_cnt_next   = BIT_LOAD;
                    if (r_bit_idx == 3'd7) begin
                        w_state_next = S_STOP;
                    end else begin
                        w_bit_idx_next = r_bit_idx + 3'd1;
                    end
                end
            end
            S_STOP: begin
                if (!w_tick) begin
                    w_cnt_next = r_cnt - 16'd1;
                end else if (r_rx_s) begin
                    w_push_req   = 1'b1;
                    w_state_next = S_IDLE;
                end else begin
                    w_frame_set  = 1'b1;
                    w_state_next = S_BREAK;
                end
            end
            S_BREAK: begin
                // A held-low line is not a new start bit; wait for it to return high.
                if (r_rx_s) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_cnt_next   = 16'd0;
            end
        endcase
    end

    // Receiver state register and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= 16'd0;
            r_bit_idx <= 3'd0;
            r_shift   <= 8'h00;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_bit_idx <= w_bit_idx_next;
            r_shift   <= w_shift_next;
        end
    end

    // FIFO control: a pop frees the slot a same-cycle push into a full FIFO needs.
    assign w_full    = (r_level == FULL_LEVEL);
    assign w_pop     = out_valid & out_ready;
    assign w_push    = w_push_req & (~w_full | w_pop);
    assign w_ovf_set = w_push_req & w_full & ~w_pop;

    // FIFO storage write port.
    // NOTE: storage is deliberately not reset; out_valid gates it, so stale entries are never seen.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= r_shift;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // Sticky flags; a set event in the same cycle as clr_flags wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_err <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (w_frame_set) begin
                frame_err <= 1'b1;
            end else if (clr_flags) begin
                frame_err <= 1'b0;
            end
            if (w_ovf_set) begin
                overflow <= 1'b1;
            end else if (clr_flags) begin
                overflow <= 1'b0;
            end
        end
    end

    assign out_valid  = (r_level != '0);
    assign out_data   = out_valid ? r_mem[r_rd_ptr] : 8'h00;
    assign fifo_level = r_level;

endmodule

// File: tb/tb_uart_rx_capture.sv
// tb_uart_rx_capture: directed scenarios plus randomized byte bursts for
// uart_rx_capture, checked against a queue-based model of the byte stream.
module tb_uart_rx_capture;

    localparam int CLK_DIV    = 8;
    localparam int FIFO_DEPTH = 4;
    // Clock edges from the line falling (at a negedge) to the stop-sample edge:
    // two synchroniser flops, one edge to leave IDLE, half a bit, then nine bits.
    localparam int STOP_EDGE  = 3 + CLK_DIV / 2 + 9 * CLK_DIV;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] fifo_level;
    logic       frame_err;
    logic       overflow;
    logic       clr_flags;

    int         n_checks = 0;
    int         n_errors = 0;

    logic [7:0] exp_q[$];
    logic       exp_ovf;
    logic       exp_ferr;

    uart_rx_capture #(
        .CLK_DIV   (CLK_DIV),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .fifo_level(fifo_level),
        .frame_err (frame_err),
        .overflow  (overflow),
        .clr_flags (clr_flags)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive one 8N1 frame starting at a negedge; the line is left at the stop level.
    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        cycles(CLK_DIV);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            cycles(CLK_DIV);
        end
        rx = stop_bit;
        cycles(CLK_DIV);
    endtask

    // Send a frame with no consumer activity and update the model accordingly.
    task automatic model_send(input logic [7:0] b, input logic stop_ok);
        send_byte(b, stop_ok);
        rx = 1'b1;
        if (!stop_ok) begin
            exp_ferr = 1'b1;
        end else if (exp_q.size() < FIFO_DEPTH) begin
            exp_q.push_back(b);
        end else begin
            exp_ovf = 1'b1;
        end
    endtask

    task automatic check_status(input string tag);
        check({tag, "_level"}, 32'(fifo_level), 32'(exp_q.size()));
        check({tag, "_valid"}, 32'(out_valid), 32'(exp_q.size() != 0));
        check({tag, "_ovf"},   32'(overflow),  32'(exp_ovf));
        check({tag, "_ferr"},  32'(frame_err), 32'(exp_ferr));
    endtask

    // Pop every modelled byte, one per cycle, comparing the FIFO head each time.
    task automatic drain(input string tag);
        logic [7:0] b;
        out_ready = 1'b1;
        while (exp_q.size() != 0) begin
            b = exp_q.pop_front();
            check({tag, "_dvalid"}, 32'(out_valid), 32'd1);
            check({tag, "_ddata"},  32'(out_data),  32'(b));
            cycles(1);
        end
        out_ready = 1'b0;
        check({tag, "_empty"}, 32'(out_valid), 32'd0);
        check({tag, "_lvl0"},  32'(fifo_level), 32'd0);
    endtask

    task automatic pulse_clr();
        clr_flags = 1'b1;
        cycles(1);
        clr_flags = 1'b0;
        exp_ferr  = 1'b0;
        exp_ovf   = 1'b0;
    endtask

    initial begin
        int         n;
        logic [7:0] b;
        logic       bad;

        rst       = 1'b1;
        rx        = 1'b1;
        out_ready = 1'b0;
        clr_flags = 1'b0;
        exp_ovf   = 1'b0;
        exp_ferr  = 1'b0;

        // Reset values after the first edge with rst high.
        cycles(1);
        check("rst_level", 32'(fifo_level), 32'd0);
        check("rst_valid", 32'(out_valid),  32'd0);
        check("rst_data",  32'(out_data),   32'd0);
        check("rst_ferr",  32'(frame_err),  32'd0);
        check("rst_ovf",   32'(overflow),   32'd0);
        cycles(3);
        rst = 1'b0;
        cycles(5);

        // Single byte, consumer stalled; byte appears the cycle after the stop sample.
        fork
            send_byte(8'hA5, 1'b1);
            begin
                cycles(STOP_EDGE - 1);
                check("a5_pre_valid", 32'(out_valid), 32'd0);
                cycles(1);
                check("a5_post_valid", 32'(out_valid), 32'd1);
                check("a5_post_data",  32'(out_data),  32'hA5);
            end
        join
        rx = 1'b1;
        exp_q.push_back(8'hA5);
        cycles(2);
        check_status("a5");
        drain("a5");

        // Short low glitch: rejected at the start sample.
        rx = 1'b0;
        cycles(3);
        rx = 1'b1;
        cycles(20);
        check_status("glitch");
        model_send(8'h3C, 1'b1);
        cycles(2);
        check_status("3c");
        drain("3c");

        // Framing error with clr_flags in the same cycle, then a long break.
        fork
            send_byte(8'h55, 1'b0);
            begin
                cycles(STOP_EDGE - 1);
                clr_flags = 1'b1;
                cycles(1);
                clr_flags = 1'b0;
                check("ferr_set_wins", 32'(frame_err), 32'd1);
            end
        join
        exp_ferr = 1'b1;
        cycles(40);
        check_status("break");
        rx = 1'b1;
        cycles(20);
        check_status("break_end");
        model_send(8'h01, 1'b1);
        cycles(2);
        check_status("01");
        drain("01");
        pulse_clr();
        check("ferr_clr", 32'(frame_err), 32'd0);

        // Overflow: five bytes into a four-entry FIFO.
        for (int i = 0; i < 5; i++) begin
            model_send(8'(8'h10 + i), 1'b1);
            cycles(3);
        end
        check_status("ovf");
        drain("ovf");
        pulse_clr();
        check("ovf_clr", 32'(overflow), 32'd0);

        // Full FIFO with a pop coinciding with the stop-sample push.
        for (int i = 0; i < 4; i++) begin
            model_send(8'(8'h20 + i), 1'b1);
            cycles(3);
        end
        check_status("full");
        fork
            send_byte(8'h77, 1'b1);
            begin
                cycles(STOP_EDGE - 1);
                out_ready = 1'b1;
                cycles(1);
                out_ready = 1'b0;
            end
        join
        rx = 1'b1;
        void'(exp_q.pop_front());
        exp_q.push_back(8'h77);
        cycles(2);
        check_status("full_pp");
        drain("full_pp");

        // Reset in the middle of a frame, with a byte already queued.
        model_send(8'h42, 1'b1);
        cycles(2);
        check_status("pre_rst");
        fork
            send_byte(8'hFF, 1'b1);
            begin
                cycles(5 * CLK_DIV + 4);
                rst = 1'b1;
                cycles(1);
                check("mid_rst_level", 32'(fifo_level), 32'd0);
                check("mid_rst_valid", 32'(out_valid),  32'd0);
                check("mid_rst_data",  32'(out_data),   32'd0);
                cycles(1);
                rst = 1'b0;
            end
        join
        rx = 1'b1;
        exp_q.delete();
        cycles(10);
        check_status("post_rst");
        model_send(8'h81, 1'b1);
        cycles(2);
        check_status("81");
        drain("81");

        // Randomized bursts with occasional framing errors and overflow.
        for (int iter = 0; iter < 8; iter++) begin
            n = int'($urandom_range(1, 6));
            for (int k = 0; k < n; k++) begin
                b   = 8'($urandom);
                bad = ($urandom_range(0, 4) == 0);
                model_send(b, !bad);
                cycles(int'($urandom_range(3, 12)));
            end
            check_status("rand");
            drain("rand");
            pulse_clr();
            check("rand_clr_ferr", 32'(frame_err), 32'd0);
            check("rand_clr_ovf",  32'(overflow),  32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
